// File: rtl/xnor_pop_pkg.sv
// Shared sizing, FSM state type and half-index encoding for the XNOR-pop loader.
package xnor_pop_pkg;

    localparam int N   = 1200;
    localparam int WW  = 40;
    localparam int WPH = N / (2 * WW);

    typedef enum logic {
        FILL  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        XLO = 2'd0,
        XHI = 2'd1,
        WLO = 2'd2,
        WHI = 2'd3
    } half_e;

endpackage

// File: rtl/xnor_pop_word_packer.sv
// Word counter and pack buffer: places word j of a half at bits [j*WW +: WW].
module xnor_pop_word_packer
    import xnor_pop_pkg::*;
#(
    parameter int WW  = xnor_pop_pkg::WW,
    parameter int WPH = xnor_pop_pkg::WPH
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              write_i,
    input  logic              clear_i,
    input  logic [WW-1:0]     word_i,
    output logic              lastSlot_o,
    output logic [WW*WPH-1:0] packNext_o
);

    localparam int HW = WW * WPH;
    localparam int CW = (WPH > 1) ? $clog2(WPH) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(WPH - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] pack_q, pack_d;
    logic [HW-1:0] merged;

    // The merged view already contains the incoming word, so the top can
    // register a complete half on the same edge that accepts its last word.
    always_comb begin
        merged = pack_q;
        merged[int'(cnt_q) * WW +: WW] = word_i;

        cnt_d  = cnt_q;
        pack_d = pack_q;
        if (clear_i) begin
            cnt_d  = '0;
            pack_d = '0;
        end else if (write_i) begin
            cnt_d  = (cnt_q == LastCnt) ? '0 : cnt_q + CW'(1);
            pack_d = merged;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q  <= '0;
            pack_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pack_q <= pack_d;
        end
    end

    assign lastSlot_o = (cnt_q == LastCnt);
    assign packNext_o = merged;

endmodule

// File: rtl/xnor_pop_loader.sv
// Streams WW-bit words into four N/2-bit halves (x-low, x-high, w-low, w-high)
// and presents each half to the popcount receiver with a one-cycle load strobe.
module xnor_pop_loader
    import xnor_pop_pkg::*;
#(
    parameter int N  = xnor_pop_pkg::N,
    parameter int WW = xnor_pop_pkg::WW
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [WW-1:0]  s_data,
    input  logic           s_last,
    output logic [N/2-1:0] in_data,
    output logic           lw1rdy,
    output logic           hw1rdy,
    output logic           lw2rdy,
    output logic           hw2rdy,
    output logic           frame_done,
    output logic           err
);

    localparam int HalfWords = N / (2 * WW);

    state_e         state_q;
    half_e          half_q;
    logic [3:0]     strobe_q;
    logic [N/2-1:0] inData_q;
    logic           frameDone_q;
    logic           err_q;

    logic           accept;
    logic           lastSlot;
    logic           finalWord;
    logic           badLast;
    logic [N/2-1:0] packNext;

    assign accept    = s_valid && (state_q == FILL);
    assign finalWord = (half_q == WHI) && lastSlot;
    assign badLast   = accept && s_last && !finalWord;

    xnor_pop_word_packer #(
        .WW  (WW),
        .WPH (HalfWords)
    ) u_packer (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .write_i    (accept && !badLast),
        .clear_i    (badLast),
        .word_i     (s_data),
        .lastSlot_o (lastSlot),
        .packNext_o (packNext)
    );

    // A misplaced s_last drops the word and restarts the frame at x-low;
    // a missing s_last on the final word still issues w-high but flags err.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= FILL;
            half_q      <= XLO;
            strobe_q    <= '0;
            inData_q    <= '0;
            frameDone_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            strobe_q    <= '0;
            frameDone_q <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                FILL: begin
                    if (badLast) begin
                        err_q  <= 1'b1;
                        half_q <= XLO;
                    end else if (accept && lastSlot) begin
                        state_q  <= ISSUE;
                        inData_q <= packNext;
                        strobe_q <= 4'b0001 << half_q;
                        if (finalWord) begin
                            frameDone_q <= s_last;
                            err_q       <= !s_last;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= FILL;
                    half_q  <= half_e'(half_q + 2'd1);
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign s_ready    = (state_q == FILL);
    assign in_data    = inData_q;
    assign lw1rdy     = strobe_q[0];
    assign hw1rdy     = strobe_q[1];
    assign lw2rdy     = strobe_q[2];
    assign hw2rdy     = strobe_q[3];
    assign frame_done = frameDone_q;
    assign err        = err_q;

endmodule

// File: doc/xnor_pop_loader.md
XNOR_POP_LOADER -- requirements
Module: xnor_pop_loader

Interface
REQ-001 Parameter: N, default 1200, total XNOR-pop vector length in bits, divisible by 2*WW.
REQ-002 Parameter: WW, default 40, input stream word width in bits.
REQ-003 Port: clk  input  1  single clock, all logic rising-edge.
REQ-004 Port: rstn  input  1  asynchronous active-low reset.
REQ-005 Port: s_valid  input  1  stream word valid.
REQ-006 Port: s_ready  output  1  stream word accepted when s_valid and s_ready are both high.
REQ-007 Port: s_data  input  WW  stream word.
REQ-008 Port: s_last  input  1  marks the final word of a frame (word 4*WPH-1, where WPH = N/(2*WW)).
REQ-009 Port: in_data  output  N/2  half-vector presented to the popcount receiver.
REQ-010 Port: lw1rdy, hw1rdy, lw2rdy, hw2rdy  output  1 each  load strobes for low x, high x, low w, high w.
REQ-011 Port: frame_done  output  1  one-cycle pulse after a complete, well-formed frame.
REQ-012 Port: err  output  1  one-cycle pulse on an s_last framing violation.

Function
REQ-013 A frame SHALL be 4*WPH words (60 at defaults), split into halves issued in fixed order: x-low, x-high, w-low, w-high.
REQ-014 Within a half, word j SHALL be packed into in_data bits [j*WW +: WW], so the first word lands at the LSBs.
REQ-015 FSM states SHALL be FILL (s_ready=1, accepting words) and ISSUE (s_ready=0, one cycle).
REQ-016 Acceptance of word WPH-1 of a half in FILL SHALL move to ISSUE on the next edge.
REQ-017 In ISSUE, in_data SHALL hold the packed half and exactly one strobe SHALL be high, selected by the half index 0..3.
REQ-018 ISSUE SHALL always return to FILL after one cycle and advance the half index, wrapping 3 to 0.
REQ-019 Strobe latency: the strobe SHALL be high in the cycle immediately after the edge that accepts the last word of its half.
REQ-020 Throughput: one half per WPH+1 cycles under continuous s_valid.
REQ-021 Strobes and in_data SHALL be registered outputs; in_data SHALL stay stable outside ISSUE until the next ISSUE.
REQ-022 frame_done SHALL pulse in the same cycle as hw2rdy when the frame had no error.
REQ-023 s_last on any word other than word 4*WPH-1 SHALL cause the following: the word is dropped, err pulses next cycle, half index and word counter clear to 0, no strobe is issued for the partial half, and the state stays FILL.
REQ-024 Missing s_last on word 4*WPH-1 SHALL still issue hw2rdy, SHALL pulse err in the same cycle as hw2rdy, and SHALL suppress frame_done.
REQ-025 s_valid low SHALL stall the word counter with no timeout; bubbles SHALL have no effect on output timing except delay.

Reset
REQ-026 rstn low SHALL asynchronously clear the following: state=FILL, half index=0, word counter=0, pack buffer=0, in_data=0, all strobes=0, frame_done=0, err=0.
REQ-027 After rstn deasserts, s_ready SHALL be 1 in the first cycle.
REQ-028 Reset mid-frame SHALL discard all partial data and issue no strobe.

Structure
REQ-029 A shared package xnor_pop_pkg SHALL hold N, WW, WPH, the FILL/ISSUE state type, and the half-index encoding (XLO=0, XHI=1, WLO=2, WHI=3).
REQ-030 One sub-module, xnor_pop_word_packer, SHALL implement the word counter and pack buffer; the top-level SHALL hold the FSM, strobes and framing checks.

Verification
REQ-031 Scenario: 60 back-to-back words, word k = k, last on word 59 -> lw1rdy at cycle 16, hw1rdy at 32, lw2rdy at 48, hw2rdy and frame_done at 64; x-low in_data[39:0]=0, [599:560]=14.
REQ-032 Scenario: same frame with s_valid low every other cycle -> same strobe order and data, each strobe one cycle after its 15th accepted word, no err.
REQ-033 Scenario: s_last on word 20 -> lw1rdy only, err pulse one cycle after word 20, the next 60-word frame issues all four strobes with correct data.
REQ-034 Scenario: 60 words with s_last never asserted -> four strobes issued, err coincident with hw2rdy, frame_done stays 0.
REQ-035 Scenario: rstn pulled low after word 30 -> all outputs 0 immediately, next frame starts at x-low, no stray strobe.
REQ-036 Scenario: all-ones x and w frame fed into a popcount receiver model -> receiver x and w registers equal all-ones after hw2rdy.
